// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage of the five-stage pipeline. Consumes the
//            EX/MEM register, performs word loads/stores over a req/ack
//            data-memory port, stalls upstream while an access is in flight
//            and loads the MEM/WB register.
// Ports    : clk, rst                  - clock, async active-high reset
//            EX_MEM_*                  - EX/MEM pipeline register contents
//            dmem_req/we/addr/wdata    - registered data-memory request
//            dmem_rdata, dmem_ack      - data-memory response
//            MEM_stall, MEM_take       - combinational pipeline controls
//            MEM_WB_rd/regwrite/result - registered MEM/WB register
//            MEM_fault                 - one-cycle misalign/timeout pulse
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_ALU_result,
    input  logic [31:0] EX_MEM_rs2_data,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic        EX_MEM_memtoreg,
    input  logic        EX_MEM_regwrite,
    input  logic        EX_MEM_branch,
    input  logic        EX_MEM_zero,
    input  logic        EX_MEM_unconditional_jmp,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        MEM_stall,
    output logic        MEM_take,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regwrite,
    output logic [31:0] MEM_WB_result,
    output logic        MEM_fault
);

    localparam int c_CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    // Last WAIT-cycle count before the access is abandoned.
    localparam logic [c_CNT_W-1:0] c_TMO_LAST =
        c_CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
    localparam logic c_TMO_EN = (ACK_TIMEOUT != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_timeout;
    logic [31:0]        r_rdata;

    logic w_pending;
    logic w_misaligned;
    logic w_tmo_hit;
    logic w_wb_regwrite;

    assign w_pending     = EX_MEM_memread | EX_MEM_memwrite;
    assign w_misaligned  = (EX_MEM_ALU_result[1:0] != 2'b00);
    assign w_tmo_hit     = c_TMO_EN && (r_wait_cnt == c_TMO_LAST);
    assign w_wb_regwrite = EX_MEM_regwrite & (EX_MEM_rd != 5'd0);

    // Stall starts in the IDLE cycle that detects an aligned access so the
    // EX/MEM register is frozen from detection until DONE.
    always_comb begin
        MEM_stall = 1'b0;
        if (r_state == S_WAIT) begin
            MEM_stall = 1'b1;
        end else if (r_state == S_IDLE && w_pending && !w_misaligned) begin
            MEM_stall = 1'b1;
        end
    end

    assign MEM_take = ((EX_MEM_branch & EX_MEM_zero) | EX_MEM_unconditional_jmp)
                      & ~MEM_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_wait_cnt      <= '0;
            r_timeout       <= 1'b0;
            r_rdata         <= 32'd0;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= 32'd0;
            dmem_wdata      <= 32'd0;
            MEM_WB_rd       <= 5'd0;
            MEM_WB_regwrite <= 1'b0;
            MEM_WB_result   <= 32'd0;
            MEM_fault       <= 1'b0;
        end else begin
            MEM_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_pending) begin
                        MEM_WB_rd       <= EX_MEM_rd;
                        MEM_WB_regwrite <= w_wb_regwrite;
                        MEM_WB_result   <= EX_MEM_ALU_result;
                    end else begin
                        // Any memory op (faulting or issued) leaves a bubble.
                        MEM_WB_rd       <= 5'd0;
                        MEM_WB_regwrite <= 1'b0;
                        MEM_WB_result   <= 32'd0;
                        if (w_misaligned) begin
                            MEM_fault <= 1'b1;
                        end else begin
                            dmem_addr  <= {EX_MEM_ALU_result[31:2], 2'b00};
                            dmem_wdata <= EX_MEM_rs2_data;
                            dmem_we    <= EX_MEM_memwrite;
                            dmem_req   <= 1'b1;
                            r_wait_cnt <= '0;
                            r_state    <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    MEM_WB_rd       <= 5'd0;
                    MEM_WB_regwrite <= 1'b0;
                    MEM_WB_result   <= 32'd0;
                    r_wait_cnt      <= r_wait_cnt + 1'b1;
                    if (dmem_ack) begin
                        r_rdata  <= dmem_rdata;
                        dmem_req <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (w_tmo_hit) begin
                        dmem_req  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    MEM_WB_rd       <= EX_MEM_rd;
                    MEM_WB_regwrite <= w_wb_regwrite & ~r_timeout;
                    MEM_WB_result   <= EX_MEM_memtoreg ? r_rdata : EX_MEM_ALU_result;
                    MEM_fault       <= r_timeout;
                    r_wait_cnt      <= '0;
                    r_timeout       <= 1'b0;
                    r_state         <= S_IDLE;
                end

                default: begin
                    dmem_req <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. Each instruction's expected
//            MEM/WB contents and handshake profile are pushed to a scoreboard
//            when it is presented and popped when the stage completes it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int c_TMO = 4;

    logic        clk;
    logic        rst;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        memread, memwrite, memtoreg, regwrite;
    logic        branch, zero, ujmp;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall, mem_take;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_result;
    logic        mem_fault;

    mem_stage #(.ACK_TIMEOUT(c_TMO)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .EX_MEM_ALU_result        (alu_result),
        .EX_MEM_rs2_data          (rs2_data),
        .EX_MEM_rd                (rd),
        .EX_MEM_memread           (memread),
        .EX_MEM_memwrite          (memwrite),
        .EX_MEM_memtoreg          (memtoreg),
        .EX_MEM_regwrite          (regwrite),
        .EX_MEM_branch            (branch),
        .EX_MEM_zero              (zero),
        .EX_MEM_unconditional_jmp (ujmp),
        .dmem_req                 (dmem_req),
        .dmem_we                  (dmem_we),
        .dmem_addr                (dmem_addr),
        .dmem_wdata               (dmem_wdata),
        .dmem_rdata               (dmem_rdata),
        .dmem_ack                 (dmem_ack),
        .MEM_stall                (mem_stall),
        .MEM_take                 (mem_take),
        .MEM_WB_rd                (wb_rd),
        .MEM_WB_regwrite          (wb_regwrite),
        .MEM_WB_result            (wb_result),
        .MEM_fault                (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] res;
        logic        chk_res;
        logic        fault;
        int          stall_n;
        int          req_n;
        int          lat;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one instruction; ack_at = WAIT cycle index carrying ack, -1 = never.
    task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] d, input logic mr, input logic mw,
                          input logic m2r, input logic rw, input logic br, input logic zr,
                          input logic jmp, input int ack_at, input logic [31:0] rdata);
        exp_t e;
        exp_t got;
        logic mem, mis, tmo, st, done;
        int   stall_n = 0, req_n = 0, lat = 0;
        logic first = 1'b1;

        mem = mr | mw;
        mis = mem && (alu[1:0] != 2'b00);
        tmo = mem && !mis && (ack_at < 0);
        e.we = mw; e.addr = {alu[31:2], 2'b00}; e.wdata = rs2; e.chk_res = 1'b1;
        if (!mem) begin
            e.rd = d; e.rw = rw && (d != 5'd0); e.res = alu; e.fault = 1'b0;
            e.stall_n = 0; e.req_n = 0; e.lat = 1;
        end else if (mis) begin
            e.rd = 5'd0; e.rw = 1'b0; e.res = 32'd0; e.fault = 1'b1;
            e.stall_n = 0; e.req_n = 0; e.lat = 1;
        end else if (tmo) begin
            e.rd = d; e.rw = 1'b0; e.res = 32'd0; e.chk_res = 1'b0; e.fault = 1'b1;
            e.stall_n = c_TMO + 1; e.req_n = c_TMO; e.lat = c_TMO + 2;
        end else begin
            e.rd = d; e.rw = rw && (d != 5'd0); e.res = m2r ? rdata : alu; e.fault = 1'b0;
            e.stall_n = ack_at + 2; e.req_n = ack_at + 1; e.lat = ack_at + 3;
        end
        sb.push_back(e);

        alu_result = alu; rs2_data = rs2; rd = d;
        memread = mr; memwrite = mw; memtoreg = m2r; regwrite = rw;
        branch = br; zero = zr; ujmp = jmp;

        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            st = mem_stall;
            if (st) stall_n++;
            if (first && ((br & zr) | jmp))
                chk({tag, ".take"}, {31'd0, mem_take}, {31'd0, (e.stall_n == 0)});
            first = 1'b0;
            if (dmem_req) begin
                if (req_n == 0) begin
                    chk({tag, ".addr"},  dmem_addr,  e.addr);
                    chk({tag, ".we"},    {31'd0, dmem_we}, {31'd0, e.we});
                    if (e.we) chk({tag, ".wdata"}, dmem_wdata, e.wdata);
                end
                if (req_n == ack_at) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
                req_n++;
            end
            @(posedge clk);
            lat++;
            #1;
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hx;
            if (!st) done = 1'b1;
        end
        if (!done) chk({tag, ".complete"}, 32'd0, 32'd1);

        got = sb.pop_front();
        chk({tag, ".lat"},   lat,     got.lat);
        chk({tag, ".stall"}, stall_n, got.stall_n);
        chk({tag, ".req"},   req_n,   got.req_n);
        chk({tag, ".rd"},    {27'd0, wb_rd},       {27'd0, got.rd});
        chk({tag, ".rw"},    {31'd0, wb_regwrite}, {31'd0, got.rw});
        if (got.chk_res) chk({tag, ".res"}, wb_result, got.res);
        chk({tag, ".fault"}, {31'd0, mem_fault},   {31'd0, got.fault});
    endtask

    initial begin
        rst = 1'b1;
        alu_result = 32'd0; rs2_data = 32'd0; rd = 5'd0;
        memread = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; regwrite = 1'b0;
        branch = 1'b0; zero = 1'b0; ujmp = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.req",   {31'd0, dmem_req},    32'd0);
        chk("rst.stall", {31'd0, mem_stall},   32'd0);
        chk("rst.rw",    {31'd0, wb_regwrite}, 32'd0);
        chk("rst.res",   wb_result,            32'd0);
        chk("rst.fault", {31'd0, mem_fault},   32'd0);
        @(posedge clk); #1;

        //      tag        alu           rs2           rd  mr mw m2r rw br zr jmp ack rdata
        run_op("add",     32'h10,       32'h0,        5,  0, 0, 0, 1, 0, 0, 0, -1, 32'h0);
        run_op("ld",      32'h100,      32'h0,        3,  1, 0, 1, 1, 0, 0, 0,  1, 32'hDEAD_BEEF);
        run_op("st",      32'h204,      32'h1234_5678, 0, 0, 1, 0, 0, 0, 0, 0,  0, 32'h0);
        run_op("mis",     32'h102,      32'h0,        7,  1, 0, 1, 1, 0, 0, 0, -1, 32'h0);
        run_op("nop_r0",  32'h55,       32'h0,        0,  0, 0, 0, 1, 0, 0, 0, -1, 32'h0);
        run_op("tmo",     32'h300,      32'h0,        9,  1, 0, 1, 1, 0, 0, 0, -1, 32'h0);
        run_op("after",   32'hABC,      32'h0,        2,  0, 0, 0, 1, 0, 0, 0, -1, 32'h0);
        run_op("ld_jmp",  32'h8,        32'h0,        31, 1, 0, 1, 1, 0, 0, 1,  0, 32'hCAFE_F00D);
        run_op("ld_b2b",  32'hC,        32'h0,        1,  1, 0, 0, 1, 0, 0, 0,  2, 32'h7777_0000);
        run_op("br",      32'h40,       32'h0,        4,  0, 0, 0, 1, 1, 1, 0, -1, 32'h0);

        // Reset while an access is outstanding.
        alu_result = 32'h400; rd = 5'd6; memread = 1'b1; memtoreg = 1'b1; regwrite = 1'b1;
        memwrite = 1'b0; branch = 1'b0; zero = 1'b0; ujmp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rstw.req_before", {31'd0, dmem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstw.req",   {31'd0, dmem_req},    32'd0);
        chk("rstw.rw",    {31'd0, wb_regwrite}, 32'd0);
        chk("rstw.fault", {31'd0, mem_fault},   32'd0);
        memread = 1'b0; memtoreg = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        run_op("post_rst", 32'h99,      32'h0,        8,  0, 0, 0, 1, 0, 0, 0, -1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
